// File: rtl/lcd_img_loader.sv
// lcd_img_loader: packs an R,G,B byte stream into 24-bit pixels and writes them to image RAM port A (optional trailer checksum via LCD_IMG_LOADER_CKSUM_EN)
module lcd_img_loader #(
   parameter int IMG_WIDTH  = 345,
   parameter int IMG_HEIGHT = 249,
   parameter int ADDR_W     = 17
) (
   input  logic              clk_in,
   input  logic              sys_rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [23:0]       ram_din,
   output logic              busy,
   output logic              done,
   output logic              cksum_ok
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
   typedef enum logic [2:0] {
      IDLE, RECV, WRITE, FIN
`ifdef LCD_IMG_LOADER_CKSUM_EN
      , CKSUM
`endif
   } state_t;
   state_t            state;
   logic [1:0]        byte_cnt;
   logic [ADDR_W-1:0] pix_cnt;
   logic [7:0]        r, g;
`ifdef LCD_IMG_LOADER_CKSUM_EN
   logic [7:0]        sum;
`endif
   // frame load FSM; every output is registered and updated alongside the state
   always_ff @(posedge clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         byte_cnt <= '0;
         pix_cnt  <= '0;
         r        <= '0;
         g        <= '0;
         s_ready  <= 1'b0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cksum_ok <= 1'b0;
`ifdef LCD_IMG_LOADER_CKSUM_EN
         sum      <= '0;
`endif
      end else begin
         ram_we <= 1'b0;
         done   <= 1'b0;
         if (busy && abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            s_ready  <= 1'b0;
            cksum_ok <= 1'b0;
            byte_cnt <= '0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  state    <= RECV;
                  busy     <= 1'b1;
                  s_ready  <= 1'b1;
                  pix_cnt  <= '0;
                  byte_cnt <= '0;
                  cksum_ok <= 1'b0;
`ifdef LCD_IMG_LOADER_CKSUM_EN
                  sum      <= '0;
`endif
               end
               RECV: if (s_valid) begin
`ifdef LCD_IMG_LOADER_CKSUM_EN
                  sum <= sum + s_data;
`endif
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd0) r <= s_data;
                  else if (byte_cnt == 2'd1) g <= s_data;
                  else begin
                     byte_cnt <= '0;
                     state    <= WRITE;
                     s_ready  <= 1'b0;
                     ram_we   <= 1'b1;
                     ram_addr <= pix_cnt;
                     ram_din  <= {r, g, s_data};
                  end
               end
               WRITE: if (pix_cnt == LAST) begin
`ifdef LCD_IMG_LOADER_CKSUM_EN
                  state    <= CKSUM;
                  s_ready  <= 1'b1;
`else
                  state    <= FIN;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cksum_ok <= 1'b1;
`endif
               end else begin
                  pix_cnt <= pix_cnt + 1'b1;
                  state   <= RECV;
                  s_ready <= 1'b1;
               end
`ifdef LCD_IMG_LOADER_CKSUM_EN
               CKSUM: if (s_valid) begin
                  cksum_ok <= (s_data == sum);
                  state    <= FIN;
                  s_ready  <= 1'b0;
                  done     <= 1'b1;
                  busy     <= 1'b0;
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
